// File: rtl/adc_chan_seq_pkg.sv
// Shared types and constants for the ADC channel sequencer (adc_chan_seq).
// Optional watchdog in the top level is enabled with `define SEQ_TIMEOUT_EN.
package adc_chan_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int RES_W  = 16;

  // Word emitted in place of a real conversion when the watchdog fires.
  localparam logic [RES_W-1:0] TIMEOUT_RESULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV,
    ST_EMIT
  } state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_chan_pick.sv
// Combinational finder for the next enabled channel above the current one,
// plus a flag telling whether the current channel is the last in the mask.
module adc_chan_pick
  import adc_chan_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  output logic [CH_W-1:0]   o_next,
  output logic              o_last
);

  logic [NUM_CH-1:0] w_above;

  assign w_above = i_mask & ({{(NUM_CH - 1){1'b1}}, 1'b0} << i_cur);
  assign o_next  = lowest_set(w_above);
  assign o_last  = (w_above == '0);

endmodule

// File: rtl/adc_chan_seq.sv
// Multi-channel SAR ADC sequencer: settles the mux, starts each conversion and
// emits one FIFO word per enabled channel. Watchdog enabled by `define SEQ_TIMEOUT_EN.
module adc_chan_seq
  import adc_chan_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              SAMPLE_CLK,
  input  logic              RST_sync,
  input  logic              ENSAMP_sync,
  input  logic [NUM_CH-1:0] CHEN,
  input  logic              FRAME_TRIG,
  input  logic              ADC_DONE,
  input  logic [RES_W-1:0]  ADC_RESULT,
  output logic              ADC_START,
  output logic [CH_W-1:0]   ADC_CHSEL,
  output logic [RES_W-1:0]  RESULT,
  output logic              DONE,
  output logic [NUM_CH-1:0] ATMCHSEL,
  output logic              LASTWORD,
  output logic              BUSY,
  output logic              FRAME_MISS_TGL,
  output logic              TIMEOUT_TGL
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [NUM_CH-1:0] r_mask;
  logic [CH_W-1:0]   r_chsel;
  logic [7:0]        r_settle_cnt;
  logic [RES_W-1:0]  r_capture;
  logic              r_miss_tgl;
  logic [CH_W-1:0]   w_pick_next;
  logic              w_pick_last;
  logic              w_settle_end;
  logic              w_conv_end;
  logic              w_timeout;

  adc_chan_pick u_pick (
    .i_mask (r_mask),
    .i_cur  (r_chsel),
    .o_next (w_pick_next),
    .o_last (w_pick_last)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0] r_to_cnt;
  logic       r_to_tgl;

  // Counts CONV cycles; fires on the last allowed cycle unless ADC_DONE shows up.
  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      r_to_cnt <= '0;
      r_to_tgl <= 1'b0;
    end else if (r_state != ST_CONV) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 10'd1;
      if (w_timeout && ENSAMP_sync) r_to_tgl <= ~r_to_tgl;
    end
  end

  assign w_timeout   = (r_state == ST_CONV) && !ADC_DONE && (r_to_cnt == TIMEOUT_LAST);
  assign TIMEOUT_TGL = r_to_tgl;
`else
  assign w_timeout   = 1'b0;
  assign TIMEOUT_TGL = 1'b0;
`endif

  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_settle_end = (r_state == ST_SETTLE) && (r_settle_cnt == SETTLE_LAST);
    w_conv_end   = (r_state == ST_CONV) && (ADC_DONE || w_timeout);
    unique case (r_state)
      ST_IDLE:   if (FRAME_TRIG && (CHEN != '0)) w_state_next = ST_SETTLE;
      ST_SETTLE: if (w_settle_end) w_state_next = ST_CONV;
      ST_CONV:   if (w_conv_end) w_state_next = ST_EMIT;
      ST_EMIT:   w_state_next = w_pick_last ? ST_IDLE : ST_SETTLE;
      default:   w_state_next = ST_IDLE;
    endcase
    // Disable overrides everything, including a trigger in the same cycle.
    if (!ENSAMP_sync) w_state_next = ST_IDLE;
  end

  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      r_mask       <= '0;
      r_chsel      <= '0;
      r_settle_cnt <= '0;
      r_capture    <= '0;
      r_miss_tgl   <= 1'b0;
    end else begin
      if (FRAME_TRIG && (r_state != ST_IDLE)) r_miss_tgl <= ~r_miss_tgl;
      unique case (r_state)
        ST_IDLE: begin
          if (w_state_next == ST_SETTLE) begin
            r_mask       <= CHEN;
            r_chsel      <= lowest_set(CHEN);
            r_settle_cnt <= '0;
          end
        end
        ST_SETTLE: r_settle_cnt <= r_settle_cnt + 8'd1;
        ST_CONV: begin
          if (w_state_next == ST_EMIT) r_capture <= ADC_DONE ? ADC_RESULT : TIMEOUT_RESULT;
        end
        ST_EMIT: begin
          if (w_state_next == ST_SETTLE) begin
            r_chsel      <= w_pick_next;
            r_settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY           = (r_state != ST_IDLE);
  assign DONE           = (r_state == ST_EMIT);
  assign ADC_START      = w_settle_end;
  assign ADC_CHSEL      = r_chsel;
  assign RESULT         = DONE ? r_capture : '0;
  assign ATMCHSEL       = DONE ? ({{(NUM_CH - 1){1'b0}}, 1'b1} << r_chsel) : '0;
  assign LASTWORD       = DONE && w_pick_last;
  assign FRAME_MISS_TGL = r_miss_tgl;

endmodule

// File: tb/tb_adc_chan_seq.sv
// Directed bench for adc_chan_seq: frame table plus hand-written corner sequences.
// Exercises the watchdog path when compiled with `define SEQ_TIMEOUT_EN.
module tb_adc_chan_seq;

  localparam int SETTLE = 4;
  localparam int TMO    = 20;

  logic        SAMPLE_CLK = 1'b0;
  logic        RST_sync;
  logic        ENSAMP_sync;
  logic [7:0]  CHEN;
  logic        FRAME_TRIG;
  logic        ADC_DONE;
  logic [15:0] ADC_RESULT;
  logic        ADC_START;
  logic [2:0]  ADC_CHSEL;
  logic [15:0] RESULT;
  logic        DONE;
  logic [7:0]  ATMCHSEL;
  logic        LASTWORD;
  logic        BUSY;
  logic        FRAME_MISS_TGL;
  logic        TIMEOUT_TGL;

  int n_checks = 0;
  int n_fail   = 0;

  adc_chan_seq #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .SAMPLE_CLK     (SAMPLE_CLK),
    .RST_sync       (RST_sync),
    .ENSAMP_sync    (ENSAMP_sync),
    .CHEN           (CHEN),
    .FRAME_TRIG     (FRAME_TRIG),
    .ADC_DONE       (ADC_DONE),
    .ADC_RESULT     (ADC_RESULT),
    .ADC_START      (ADC_START),
    .ADC_CHSEL      (ADC_CHSEL),
    .RESULT         (RESULT),
    .DONE           (DONE),
    .ATMCHSEL       (ATMCHSEL),
    .LASTWORD       (LASTWORD),
    .BUSY           (BUSY),
    .FRAME_MISS_TGL (FRAME_MISS_TGL),
    .TIMEOUT_TGL    (TIMEOUT_TGL)
  );

  always #5 SAMPLE_CLK = ~SAMPLE_CLK;

  typedef struct {
    string       name;
    logic [7:0]  chen;
    int          dly;       // cycles from ADC_START to ADC_DONE
    int          exp_n;
    logic [63:0] exp_sels;  // byte i = ATMCHSEL of word i
    logic [7:0]  exp_lasts; // bit i = LASTWORD of word i
    int          retrig_at; // cycle of a second FRAME_TRIG, -1 for none
  } frame_vec_t;

  frame_vec_t vecs[5];

  task automatic tick();
    @(posedge SAMPLE_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] all_outs();
    return {ADC_START, ADC_CHSEL, RESULT, DONE, ATMCHSEL, LASTWORD, BUSY, FRAME_MISS_TGL, TIMEOUT_TGL};
  endfunction

  // Waits (bounded) until ADC_START is visible in the current cycle.
  task automatic wait_start(input string name, output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    while (cycles < 50 && !found) begin
      if (ADC_START) found = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
    chk({name, "_start_seen"}, 64'(found), 64'd1);
  endtask

  // Trigger at cycle 0 and act as the SAR core until the frame finishes.
  task automatic run_frame(input frame_vec_t v);
    int          t, words, start_t, done_t, first_start;
    logic [63:0] sels;
    logic [7:0]  lasts;
    logic [15:0] exp_res;
    logic        miss0, ended;
    t = 0; words = 0; start_t = -1; done_t = -100; first_start = -1;
    sels = '0; lasts = '0; ended = 1'b0;
    miss0 = FRAME_MISS_TGL;
    CHEN = v.chen;
    FRAME_TRIG = 1'b1;
    tick();
    t = 1;
    FRAME_TRIG = 1'b0;
    CHEN = ~v.chen;  // mid-frame mask change must be ignored
    while (t < 400 && !ended) begin
      if (!BUSY) ended = 1'b1;
      else begin
        if (ADC_START) begin
          if (first_start < 0) first_start = t;
          start_t = t;
          if (words < 8)
            chk($sformatf("%s_chsel%0d", v.name, words), 64'(8'd1 << ADC_CHSEL),
                64'(v.exp_sels[words*8 +: 8]));
        end
        if (DONE) begin
          exp_res = 16'hC000 + 16'(words * 257);
          $display("%s word %0d: sel=%02h result=%04h last=%0b", v.name, words, ATMCHSEL, RESULT, LASTWORD);
          chk($sformatf("%s_lat%0d", v.name, words), 64'(t), 64'(done_t + 1));
          chk($sformatf("%s_res%0d", v.name, words), 64'(RESULT), 64'(exp_res));
          if (words < 8) begin
            sels[words*8 +: 8] = ATMCHSEL;
            lasts[words] = LASTWORD;
          end
          words++;
        end
        ADC_DONE = 1'b0;
        if (start_t >= 0 && t == start_t + v.dly) begin
          ADC_DONE   = 1'b1;
          ADC_RESULT = 16'hC000 + 16'(words * 257);
          done_t     = t;
          start_t    = -1;
        end
        FRAME_TRIG = (t == v.retrig_at);
        tick();
        t++;
      end
    end
    chk({v.name, "_frame_ended"}, 64'(ended), 64'd1);
    ADC_DONE = 1'b0;
    FRAME_TRIG = 1'b0;
    repeat (3) begin
      if (DONE) words++;
      tick();
    end
    chk({v.name, "_count"}, 64'(words), 64'(v.exp_n));
    chk({v.name, "_sels"}, sels, v.exp_sels);
    chk({v.name, "_lasts"}, 64'(lasts), 64'(v.exp_lasts));
    chk({v.name, "_first_start"}, 64'(first_start), 64'(SETTLE));
    chk({v.name, "_miss_tgl"}, 64'(FRAME_MISS_TGL ^ miss0), 64'(v.retrig_at >= 0));
    chk({v.name, "_tmo_tgl"}, 64'(TIMEOUT_TGL), 64'd0);
  endtask

  initial begin
    int   n, extra;
    logic tgl0;

    vecs[0] = '{"ch05", 8'h05, 10, 2, 64'h0000_0000_0000_0401, 8'h02, -1};
    vecs[1] = '{"ch80", 8'h80, 3, 1, 64'h0000_0000_0000_0080, 8'h01, -1};
    vecs[2] = '{"ch5A", 8'h5A, 2, 4, 64'h0000_0000_4010_0802, 8'h08, -1};
    vecs[3] = '{"retrig", 8'h01, 5, 1, 64'h0000_0000_0000_0001, 8'h01, 6};
    vecs[4] = '{"chFF", 8'hFF, 1, 8, 64'h8040_2010_0804_0201, 8'h80, -1};

    // Reset holds everything at zero even with enable and a trigger present.
    RST_sync = 1'b1; ENSAMP_sync = 1'b1; CHEN = 8'hFF; FRAME_TRIG = 1'b1;
    ADC_DONE = 1'b0; ADC_RESULT = 16'h0;
    tick();
    tick();
    chk("reset_outputs", 64'(all_outs()), 64'd0);
    RST_sync = 1'b0; FRAME_TRIG = 1'b0;
    tick();
    chk("post_reset_idle", 64'(BUSY), 64'd0);

    // Trigger with an empty mask is ignored.
    CHEN = 8'h00; FRAME_TRIG = 1'b1;
    tick();
    FRAME_TRIG = 1'b0;
    chk("chen0_busy", 64'(BUSY), 64'd0);
    extra = 0;
    repeat (8) begin
      if (DONE || ADC_START || FRAME_MISS_TGL) extra++;
      tick();
    end
    chk("chen0_no_output", 64'(extra), 64'd0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Disable right after the first word of a full-mask frame.
    CHEN = 8'hFF; FRAME_TRIG = 1'b1;
    tick();
    FRAME_TRIG = 1'b0;
    wait_start("drop", n);
    tick();
    tick();
    ADC_DONE = 1'b1; ADC_RESULT = 16'h1234;
    tick();
    ADC_DONE = 1'b0;
    chk("drop_first_done", 64'(DONE), 64'd1);
    chk("drop_first_result", 64'(RESULT), 64'h1234);
    ENSAMP_sync = 1'b0;
    tick();
    chk("drop_busy", 64'(BUSY), 64'd0);
    chk("drop_quiet", 64'({DONE, ADC_START, LASTWORD}), 64'd0);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      ADC_DONE = (i % 5 == 4);
      if (DONE || ADC_START || BUSY) extra++;
      tick();
    end
    ADC_DONE = 1'b0;
    chk("drop_no_more_words", 64'(extra), 64'd0);

    // Trigger and disable in the same cycle: disable wins.
    CHEN = 8'h01; FRAME_TRIG = 1'b1;
    tick();
    FRAME_TRIG = 1'b0; ENSAMP_sync = 1'b1;
    chk("disable_wins", 64'(BUSY), 64'd0);
    tick();
    chk("disable_wins_later", 64'(BUSY), 64'd0);

    // ADC_DONE withheld.
    CHEN = 8'h01; FRAME_TRIG = 1'b1;
    tick();
    FRAME_TRIG = 1'b0;
    wait_start("tmo", n);
    tgl0 = TIMEOUT_TGL;
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (n < TMO + 20 && !DONE) begin
      ADC_RESULT = 16'hFFFF;
      tick();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'(TMO + 1));
    chk("tmo_result", 64'(RESULT), 64'd0);
    chk("tmo_toggle", 64'(TIMEOUT_TGL), 64'(~tgl0));
    chk("tmo_last", 64'(LASTWORD), 64'd1);
    tick();
    chk("tmo_idle", 64'(BUSY), 64'd0);
`else
    extra = 0;
    repeat (TMO + 10) begin
      tick();
      if (DONE) extra++;
    end
    chk("notmo_no_done", 64'(extra), 64'd0);
    chk("notmo_busy", 64'(BUSY), 64'd1);
    chk("notmo_toggle", 64'(TIMEOUT_TGL), 64'(tgl0));
    ADC_DONE = 1'b1; ADC_RESULT = 16'h5A5A;
    tick();
    ADC_DONE = 1'b0;
    chk("notmo_late_done", 64'(DONE), 64'd1);
    chk("notmo_late_result", 64'(RESULT), 64'h5A5A);
    tick();
    chk("notmo_idle", 64'(BUSY), 64'd0);
`endif

    // Reset in CONV, with ADC_DONE arriving in the same cycle.
    CHEN = 8'h0C; FRAME_TRIG = 1'b1;
    tick();
    FRAME_TRIG = 1'b0;
    wait_start("rst", n);
    chk("rst_chsel_before", 64'(ADC_CHSEL), 64'd2);
    tick();
    tick();
    RST_sync = 1'b1; ADC_DONE = 1'b1; ADC_RESULT = 16'hBEEF;
    tick();
    chk("rst_mid_outputs", 64'(all_outs()), 64'd0);
    RST_sync = 1'b0;
    extra = 0;
    repeat (6) begin
      tick();
      if (DONE || BUSY) extra++;
    end
    ADC_DONE = 1'b0;
    chk("rst_done_ignored", 64'(extra), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
